// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiply / restoring divide with HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiWE,
  input  logic             LoWE,
  input  logic [WIDTH-1:0] WD,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a, mag_a, mag_b, q, rem;
  logic [2*WIDTH-1:0] r, r_step, prod;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH:0] sh;
  logic [1:0] op_q;
  logic sa, sb, dz_q, go, dz, sgn, last;
  assign Busy = state == CALC;
  // a holds the multiplicand or divisor magnitude; r is {upper, lower} working pair
  always_comb begin
    sgn = ~Op[0];
    mag_a = (sgn & SrcA[WIDTH-1]) ? -SrcA : SrcA;
    mag_b = (sgn & SrcB[WIDTH-1]) ? -SrcB : SrcB;
    dz = Op[1] & ~|SrcB;
    go = Start & (state != CALC) & ~dz_q;
    last = cnt == CW'(WIDTH);
    sum = {1'b0, r[2*WIDTH-1:WIDTH]} + (r[0] ? {1'b0, a} : '0);
    sh = {r, 1'b0};
    diff = sh[2*WIDTH:WIDTH] - {1'b0, a};
    r_step = op_q[1] ? (diff[WIDTH] ? sh[2*WIDTH-1:0] : {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1})
                     : {sum, r[WIDTH-1:1]};
    prod = (~op_q[0] & (sa ^ sb)) ? -r : r;
    q = (~op_q[0] & (sa ^ sb)) ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    rem = (~op_q[0] & sa) ? -r[2*WIDTH-1:WIDTH] : r[2*WIDTH-1:WIDTH];
    state_n = (state == CALC) ? (last ? DONE : CALC) : go ? (dz ? DONE : CALC) : IDLE;
  end
  // a zero divisor parks the raw dividend in r and publishes it one edge later
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      r <= '0;
      op_q <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      dz_q <= 1'b0;
      HI <= '0;
      LO <= '0;
      Done <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      state <= state_n;
      Done <= 1'b0;
      dz_q <= 1'b0;
      if (dz_q) begin
        HI <= r[WIDTH-1:0];
        LO <= '1;
        Done <= 1'b1;
        DivByZero <= 1'b1;
      end else if (go) begin
        DivByZero <= 1'b0;
        dz_q <= dz;
        op_q <= Op;
        cnt <= '0;
        sa <= sgn & SrcA[WIDTH-1];
        sb <= sgn & SrcB[WIDTH-1];
        a <= Op[1] ? mag_b : mag_a;
        r <= dz ? {{WIDTH{1'b0}}, SrcA} : {{WIDTH{1'b0}}, Op[1] ? mag_a : mag_b};
      end else if (Busy) begin
        if (last) begin
          {HI, LO} <= op_q[1] ? {rem, q} : prod;
          Done <= 1'b1;
        end else begin
          r <= r_step;
          cnt <= cnt + CW'(1);
        end
      end else begin
        if (HiWE) HI <= WD;
        if (LoWE) LO <= WD;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for mult_div_unit
module tb_mult_div_unit;
  logic CLK = 0, RST = 1, Start = 0, HiWE = 0, LoWE = 0;
  logic [1:0] Op = 0;
  logic [31:0] SrcA = 0, SrcB = 0, WD = 0;
  logic Busy, Done, DivByZero;
  logic [31:0] HI, LO;
  int vecs = 0, errs = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t mul_v [5] = '{
    '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
    '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
    '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001},
    '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000},
    '{2'b00, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000}
  };
  vec_t div_v [6] = '{
    '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003},
    '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003},
    '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF}
  };

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWE(HiWE), .LoWE(LoWE), .WD(WD), .Busy(Busy), .Done(Done),
    .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    Start = 1; Op = op; SrcA = a; SrcB = b;
    @(posedge CLK); #1;
    Start = 0; SrcA = 32'h5A5A0F0F; SrcB = 32'h0; Op = ~op;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = Busy ? 1 : 0;
    while (!Done && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (Busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    #1;
    vecs++;
    if ({HI, LO} !== 64'h0 || {Busy, Done, DivByZero} !== 3'b000) begin
      errs++;
      $display("FAIL reset: HI=%h LO=%h bdz=%b want 0 0 000", HI, LO, {Busy, Done, DivByZero});
    end
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_multiply;
    int cyc, bn;
    foreach (mul_v[i]) begin
      start_op(mul_v[i].op, mul_v[i].a, mul_v[i].b);
      wait_done(cyc, bn);
      vecs++;
      if (cyc !== 33 || bn !== 33) begin
        errs++;
        $display("FAIL mul%0d latency: done=%0d busy=%0d want 33 33", i, cyc, bn);
      end
      vecs++;
      if (HI !== mul_v[i].hi || LO !== mul_v[i].lo || DivByZero !== 1'b0) begin
        errs++;
        $display("FAIL mul%0d result: HI=%h LO=%h dz=%b want %h %h 0", i, HI, LO, DivByZero, mul_v[i].hi, mul_v[i].lo);
      end
    end
  endtask

  task automatic test_divide;
    int cyc, bn;
    foreach (div_v[i]) begin
      start_op(div_v[i].op, div_v[i].a, div_v[i].b);
      wait_done(cyc, bn);
      vecs++;
      if (cyc !== 33) begin
        errs++;
        $display("FAIL div%0d latency: got %0d want 33", i, cyc);
      end
      vecs++;
      if (HI !== div_v[i].hi || LO !== div_v[i].lo || DivByZero !== 1'b0) begin
        errs++;
        $display("FAIL div%0d result: HI=%h LO=%h dz=%b want %h %h 0", i, HI, LO, DivByZero, div_v[i].hi, div_v[i].lo);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int cyc, bn;
    start_op(2'b11, 32'h00001234, 32'h0);
    wait_done(cyc, bn);
    vecs++;
    if (cyc !== 1 || bn !== 0) begin
      errs++;
      $display("FAIL dz_latency: done=%0d busy=%0d want 1 0", cyc, bn);
    end
    vecs++;
    if (HI !== 32'h00001234 || LO !== 32'hFFFFFFFF || DivByZero !== 1'b1) begin
      errs++;
      $display("FAIL dz_result: HI=%h LO=%h dz=%b want 00001234 ffffffff 1", HI, LO, DivByZero);
    end
    repeat (3) @(posedge CLK);
    #1;
    vecs++;
    if (DivByZero !== 1'b1 || Done !== 1'b0) begin
      errs++;
      $display("FAIL dz_hold: dz=%b done=%b want 1 0", DivByZero, Done);
    end
    start_op(2'b10, 32'hFFFFFFF0, 32'h0);
    wait_done(cyc, bn);
    vecs++;
    if (HI !== 32'hFFFFFFF0 || LO !== 32'hFFFFFFFF || bn !== 0) begin
      errs++;
      $display("FAIL dz_signed: HI=%h LO=%h busy=%0d want fffffff0 ffffffff 0", HI, LO, bn);
    end
    start_op(2'b01, 32'h2, 32'h3);
    vecs++;
    if (DivByZero !== 1'b0 || Busy !== 1'b1) begin
      errs++;
      $display("FAIL dz_clear: dz=%b busy=%b want 0 1", DivByZero, Busy);
    end
    wait_done(cyc, bn);
    vecs++;
    if (HI !== 32'h0 || LO !== 32'h6) begin
      errs++;
      $display("FAIL after_dz: HI=%h LO=%h want 0 6", HI, LO);
    end
  endtask

  task automatic test_ignore_busy;
    int cyc, bn;
    start_op(2'b01, 32'h3, 32'h5);
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    Start = 1; Op = 2'b11; SrcA = 32'd99; SrcB = 32'd3; HiWE = 1; LoWE = 1; WD = 32'hDEADBEEF;
    @(posedge CLK); #1;
    Start = 0; HiWE = 0; LoWE = 0;
    vecs++;
    if (Busy !== 1'b1 || HI !== 32'h0 || LO !== 32'h6) begin
      errs++;
      $display("FAIL busy_hold: busy=%b HI=%h LO=%h want 1 0 6", Busy, HI, LO);
    end
    wait_done(cyc, bn);
    vecs++;
    if (cyc !== 27 || HI !== 32'h0 || LO !== 32'hF) begin
      errs++;
      $display("FAIL busy_result: done=%0d HI=%h LO=%h want 27 0 f", cyc, HI, LO);
    end
    @(posedge CLK); #1;
    vecs++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errs++;
      $display("FAIL no_restart: busy=%b done=%b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    start_op(2'b00, 32'h5, 32'h6);
    repeat (10) @(posedge CLK);
    #1;
    RST = 1;
    #1;
    vecs++;
    if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid: HI=%h LO=%h busy=%b done=%b want 0 0 0 0", HI, LO, Busy, Done);
    end
    @(negedge CLK);
    RST = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done || Busy) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL rst_no_done: got %0d active samples want 0", seen);
    end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge CLK);
    HiWE = 1; WD = 32'hA5A5A5A5;
    @(posedge CLK); #1;
    HiWE = 0;
    vecs++;
    if (HI !== 32'hA5A5A5A5 || LO !== 32'h0) begin
      errs++;
      $display("FAIL mthi: HI=%h LO=%h want a5a5a5a5 0", HI, LO);
    end
    @(negedge CLK);
    LoWE = 1; WD = 32'h12345678;
    @(posedge CLK); #1;
    LoWE = 0;
    vecs++;
    if (HI !== 32'hA5A5A5A5 || LO !== 32'h12345678) begin
      errs++;
      $display("FAIL mtlo: HI=%h LO=%h want a5a5a5a5 12345678", HI, LO);
    end
    @(negedge CLK);
    HiWE = 1; LoWE = 1; WD = 32'h0F0F0F0F;
    @(posedge CLK); #1;
    HiWE = 0; LoWE = 0;
    vecs++;
    if (HI !== 32'h0F0F0F0F || LO !== 32'h0F0F0F0F) begin
      errs++;
      $display("FAIL mt_both: HI=%h LO=%h want 0f0f0f0f 0f0f0f0f", HI, LO);
    end
  endtask

  task automatic test_start_wins;
    int cyc, bn;
    @(negedge CLK);
    Start = 1; Op = 2'b01; SrcA = 32'd4; SrcB = 32'd5; HiWE = 1; LoWE = 1; WD = 32'hFFFFFFFF;
    @(posedge CLK); #1;
    Start = 0; HiWE = 0; LoWE = 0;
    vecs++;
    if (Busy !== 1'b1 || HI !== 32'h0F0F0F0F || LO !== 32'h0F0F0F0F) begin
      errs++;
      $display("FAIL start_wins: busy=%b HI=%h LO=%h want 1 0f0f0f0f 0f0f0f0f", Busy, HI, LO);
    end
    wait_done(cyc, bn);
    vecs++;
    if (cyc !== 33 || HI !== 32'h0 || LO !== 32'h14) begin
      errs++;
      $display("FAIL start_wins_result: done=%0d HI=%h LO=%h want 33 0 14", cyc, HI, LO);
    end
  endtask

  initial begin
    test_reset;
    test_multiply;
    test_divide;
    test_div_by_zero;
    test_ignore_busy;
    test_rst_mid;
    test_mthi_mtlo;
    test_start_wins;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers. Executes MULT, MULTU, DIV and DIVU on operands taken directly from the register file read ports (RD1 -> SrcA, RD2 -> SrcB).
- HI/LO results return to the register file write path through the MFHI/MFLO datapath mux.
- Runs one iteration per cycle. The control unit stalls the PC on Busy.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  launch operation; sampled only in IDLE or DONE.
- Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- SrcA  input  WIDTH  multiplicand / dividend (from RD1).
- SrcB  input  WIDTH  multiplier / divisor (from RD2).
- HiWE  input  1  MTHI write enable.
- LoWE  input  1  MTLO write enable.
- WD  input  WIDTH  MTHI/MTLO write data (from RD1).
- Busy  output  1  high while iterating; control stalls the PC.
- Done  output  1  one-cycle pulse when HI/LO take a new result.
- DivByZero  output  1  high with Done when the divisor was zero; cleared on the next Start.
- HI  output  WIDTH  product upper half / remainder.
- LO  output  WIDTH  product lower half / quotient.

Behaviour:
- Reset (async, immediate): state IDLE, HI=0, LO=0, Busy=0, Done=0, DivByZero=0, iteration counter=0, working registers=0.
- States:
  - IDLE -> CALC on Start with nonzero divisor or any multiply.
  - IDLE -> DONE on Start with DIV/DIVU and SrcB=0.
  - CALC -> DONE after WIDTH iterations.
  - DONE -> CALC/DONE on Start (same rules as IDLE); else -> IDLE.
- Latency:
  - Start sampled at edge 0; Busy high from edge 0 through edge WIDTH.
  - At edge WIDTH+1: HI/LO loaded, Done=1, Busy=0. For WIDTH=32, Done is visible 33 cycles after Start.
  - Divide-by-zero: Done at edge 1, Busy never asserted.
- Operand capture:
  - SrcA, SrcB and Op are latched at Start; later input changes have no effect.
  - Signed ops convert each operand to magnitude (two's complement negate when MSB=1) and record the sign bits.
- Multiply:
  - Shift-add on magnitudes, 2*WIDTH-bit product.
  - Signed: negate the full 2*WIDTH product if the signs differ.
  - {HI,LO} = product.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle, MSB first.
  - Signed: quotient negated if the signs differ; remainder takes the dividend's sign.
  - LO=quotient, HI=remainder.
  - 0x80000000 / -1 (signed) yields LO=0x80000000, HI=0; no trap.
- Divide by zero: HI=SrcA, LO=all ones, DivByZero=1.
- HI/LO hold their previous values during CALC; working registers are internal.
- Start while Busy: ignored, no restart.
- HiWE/LoWE:
  - In IDLE or DONE with Start low: HI<=WD / LO<=WD at the edge.
  - Both high: both registers are written.
  - Ignored while Busy.
  - Start and HiWE/LoWE on the same edge: Start wins, the write is dropped.
- Reset mid-operation aborts the computation and clears HI/LO; no Done is produced.
- Done and DivByZero are registered outputs. Busy is decoded from the state register.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy for 33 cycles; Done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> Done one cycle after Start; Busy stays 0; DivByZero=1; HI=0x1234, LO=0xFFFFFFFF.
- Start and HiWE pulsed during CALC -> both ignored, original result completes.
  - Then RST at iteration 10 of a new MULT -> HI=LO=0, Busy=0 immediately, no Done.
  - Then HiWE with WD=0xA5A5A5A5 in IDLE -> HI=0xA5A5A5A5, LO unchanged.
